// File: rtl/iir_allpole_serial_if.sv
// Sample stream bundle for iir_allpole_serial: input x[n] handshake, output y[n] handshake
// and the per-sample saturation flag.
interface iir_allpole_serial_if #(
    parameter int DATA_WIDTH = 24
);
    logic [DATA_WIDTH-1:0] iv_din;
    logic                  i_valid;
    logic                  o_ready;
    logic [DATA_WIDTH-1:0] ov_dout;
    logic                  o_valid;
    logic                  i_ready;
    logic                  o_sat;

    modport master (
        output iv_din, i_valid, i_ready,
        input  o_ready, ov_dout, o_valid, o_sat
    );

    modport slave (
        input  iv_din, i_valid, i_ready,
        output o_ready, ov_dout, o_valid, o_sat
    );
endinterface

// File: rtl/iir_allpole_serial.sv
// Time-multiplexed all-pole section y[n] = x[n] - sum a[k]*y[n-k] using a single multiplier,
// one MAC per cycle, saturating Q1.(DATA_WIDTH-1) output and ready/valid on both sides.
module iir_allpole_serial #(
    parameter  int DATA_WIDTH = 24,
    parameter  int ORDER      = 4,
    localparam int AW         = (ORDER > 1) ? $clog2(ORDER) : 1
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    iir_allpole_serial_if.slave   strm,
    input  logic                  i_coef_we,
    input  logic [AW-1:0]         iv_coef_addr,
    input  logic [DATA_WIDTH-1:0] iv_coef
);
    localparam int ACC_W = 2*DATA_WIDTH + $clog2(ORDER+1) + 1;
    localparam int TOP_W = ACC_W - 2*DATA_WIDTH + 2;
    localparam logic [AW-1:0] K_LAST  = AW'(ORDER - 1);
    localparam logic [AW:0]   ORDER_W = (AW+1)'(ORDER);
    localparam logic [DATA_WIDTH-1:0] SAT_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
    localparam logic [DATA_WIDTH-1:0] SAT_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

    state_t                         state, state_nxt;
    logic        [AW-1:0]           k;
    logic signed [ACC_W-1:0]        acc;
    logic signed [DATA_WIDTH-1:0]   coef [ORDER];
    logic signed [DATA_WIDTH-1:0]   hist [ORDER];
    logic        [DATA_WIDTH-1:0]   dout;
    logic                           dout_valid;
    logic                           dout_sat;

    logic signed [2*DATA_WIDTH-1:0] prod;
    logic signed [ACC_W-1:0]        prod_ext;
    logic signed [ACC_W-1:0]        acc_nxt;
    logic signed [ACC_W-1:0]        acc_init;
    logic        [TOP_W-1:0]        acc_top;
    logic                           ovf;

    // Input sample aligned to the accumulator's binary point (2*DATA_WIDTH-2 fraction bits).
    assign acc_init = {{(ACC_W-2*DATA_WIDTH+1){strm.iv_din[DATA_WIDTH-1]}},
                       strm.iv_din, {(DATA_WIDTH-1){1'b0}}};
    assign prod     = coef[k] * hist[k];
    assign prod_ext = {{(ACC_W-2*DATA_WIDTH){prod[2*DATA_WIDTH-1]}}, prod};
    assign acc_nxt  = acc - prod_ext;
    assign acc_top  = acc_nxt[ACC_W-1:2*DATA_WIDTH-2];
    assign ovf      = !((&acc_top) || !(|acc_top));

    // NOTE: combinational blocks assign every output a default first so no latch is inferred.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (strm.i_valid)  state_nxt = MAC;
            MAC:     if (k == K_LAST)   state_nxt = OUT;
            OUT:     if (strm.i_ready)  state_nxt = IDLE;
            default:                    state_nxt = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= IDLE;
            k          <= '0;
            acc        <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            dout_sat   <= 1'b0;
            // NOTE: coef/hist are small flop banks that must start at zero (pass-through,
            // empty history), so unlike a RAM they are cleared by reset.
            for (int i = 0; i < ORDER; i++) begin
                coef[i] <= '0;
                hist[i] <= '0;
            end
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (i_coef_we && ({1'b0, iv_coef_addr} < ORDER_W))
                        coef[iv_coef_addr] <= iv_coef;
                    if (strm.i_valid) begin
                        acc <= acc_init;
                        k   <= '0;
                    end
                end
                MAC: begin
                    acc <= acc_nxt;
                    k   <= k + 1'b1;
                    if (k == K_LAST) begin
                        dout       <= ovf ? (acc_nxt[ACC_W-1] ? SAT_MIN : SAT_MAX)
                                          : acc_nxt[2*DATA_WIDTH-2:DATA_WIDTH-1];
                        dout_sat   <= ovf;
                        dout_valid <= 1'b1;
                    end
                end
                OUT: begin
                    // History takes the value actually delivered, saturated or not.
                    if (strm.i_ready) begin
                        dout_valid <= 1'b0;
                        hist[0]    <= dout;
                        for (int i = 1; i < ORDER; i++) hist[i] <= hist[i-1];
                    end
                end
                default: ;
            endcase
        end
    end

    assign strm.o_ready = (state == IDLE);
    assign strm.ov_dout = dout;
    assign strm.o_valid = dout_valid;
    assign strm.o_sat   = dout_sat;
endmodule

// File: tb/tb_iir_allpole_serial.sv
// Self-checking bench for iir_allpole_serial: directed cases plus random samples/coefficients
// compared against a plain-arithmetic model of y[n] = x[n] - sum a[k]*y[n-k].
module tb_iir_allpole_serial;
    localparam int DW    = 24;
    // ORDER=3 leaves address ORDER representable on the 2-bit coefficient address.
    localparam int ORDER = 3;
    localparam int AW    = (ORDER > 1) ? $clog2(ORDER) : 1;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          coef_we = 1'b0;
    logic [AW-1:0] coef_addr = '0;
    logic [DW-1:0] coef_val = '0;

    int n_pass   = 0;
    int n_checks = 0;

    longint m_coef [ORDER];
    longint m_hist [ORDER];

    iir_allpole_serial_if #(.DATA_WIDTH(DW)) bus ();

    iir_allpole_serial #(.DATA_WIDTH(DW), .ORDER(ORDER)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .strm         (bus),
        .i_coef_we    (coef_we),
        .iv_coef_addr (coef_addr),
        .iv_coef      (coef_val)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    function automatic void model_reset();
        for (int i = 0; i < ORDER; i++) begin
            m_coef[i] = 0;
            m_hist[i] = 0;
        end
    endfunction

    function automatic void model_write(input int addr, input logic [DW-1:0] v);
        if (addr < ORDER) m_coef[addr] = longint'($signed(v));
    endfunction

    // Exact difference equation in 64-bit integers, then floor to Q1.23 and clamp.
    function automatic void model_calc(input logic [DW-1:0] x, output logic [DW-1:0] y,
                                       output logic s);
        longint a;
        longint q;
        a = longint'($signed(x)) * 64'sd8388608;
        for (int i = 0; i < ORDER; i++) a = a - m_coef[i] * m_hist[i];
        q = a >>> 23;
        s = 1'b0;
        if (q > 64'sd8388607) begin
            q = 64'sd8388607;
            s = 1'b1;
        end else if (q < -64'sd8388608) begin
            q = -64'sd8388608;
            s = 1'b1;
        end
        y = q[DW-1:0];
    endfunction

    function automatic void model_shift(input logic [DW-1:0] y);
        for (int i = ORDER-1; i > 0; i--) m_hist[i] = m_hist[i-1];
        m_hist[0] = longint'($signed(y));
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        model_reset();
    endtask

    task automatic wr(input int addr, input logic [DW-1:0] v);
        coef_we   = 1'b1;
        coef_addr = AW'(addr);
        coef_val  = v;
        tick();
        coef_we   = 1'b0;
        model_write(addr, v);
    endtask

    // One full sample transaction: accept, optional MAC-time write, latency, output,
    // optional backpressure hold, handshake.
    task automatic send(input logic [DW-1:0] x, input int hold, input bit acc_we,
                        input int acc_addr, input logic [DW-1:0] acc_val, input bit mac_we,
                        output logic [DW-1:0] got, output logic got_sat);
        logic [DW-1:0] ey;
        logic          es;
        int            cnt;
        check("ready_idle", bus.o_ready, 1'b1);
        bus.iv_din  = x;
        bus.i_valid = 1'b1;
        coef_we     = acc_we;
        coef_addr   = AW'(acc_addr);
        coef_val    = acc_val;
        tick();
        if (acc_we) model_write(acc_addr, acc_val);
        model_calc(x, ey, es);
        bus.i_valid = 1'b0;
        coef_we     = 1'b0;
        bus.iv_din  = DW'($urandom);
        cnt = 0;
        if (mac_we) begin
            coef_we   = 1'b1;
            coef_addr = '0;
            coef_val  = DW'($urandom);
            tick();
            coef_we   = 1'b0;
            cnt = 1;
        end
        while (!bus.o_valid && cnt < 40) begin
            tick();
            cnt++;
        end
        check("latency", 64'(cnt), 64'(ORDER));
        check("dout", bus.ov_dout, ey);
        check("sat", bus.o_sat, es);
        got     = bus.ov_dout;
        got_sat = bus.o_sat;
        for (int i = 0; i < hold; i++) begin
            bus.i_valid = 1'b1;
            bus.iv_din  = DW'($urandom);
            tick();
            check("hold_dout", bus.ov_dout, ey);
            check("hold_sat", bus.o_sat, es);
            check("hold_valid", bus.o_valid, 1'b1);
            check("hold_ready", bus.o_ready, 1'b0);
        end
        bus.i_valid = 1'b0;
        bus.i_ready = 1'b1;
        tick();
        bus.i_ready = 1'b0;
        model_shift(ey);
        check("valid_drop", bus.o_valid, 1'b0);
    endtask

    initial begin
        logic [DW-1:0] got;
        logic          gs;
        bus.iv_din  = '0;
        bus.i_valid = 1'b0;
        bus.i_ready = 1'b0;
        do_reset();
        check("rst_valid", bus.o_valid, 1'b0);
        check("rst_ready", bus.o_ready, 1'b1);
        check("rst_dout",  bus.ov_dout, '0);
        check("rst_sat",   bus.o_sat, 1'b0);

        // Pass-through with zero coefficients.
        send(24'h123456, 0, 0, 0, '0, 0, got, gs);
        check("pass0", got, 24'h123456);
        send(24'h800000, 0, 0, 0, '0, 0, got, gs);
        check("pass1", got, 24'h800000);
        send(24'h7FFFFF, 0, 0, 0, '0, 0, got, gs);
        check("pass2", got, 24'h7FFFFF);

        // First-order decay with a1 = -0.5; the third sample is held off for 5 cycles.
        do_reset();
        wr(0, 24'hC00000);
        send(24'h400000, 0, 0, 0, '0, 0, got, gs);
        check("decay0", got, 24'h400000);
        send(24'h000000, 0, 0, 0, '0, 0, got, gs);
        check("decay1", got, 24'h200000);
        send(24'h000000, 5, 0, 0, '0, 0, got, gs);
        check("decay2", got, 24'h100000);
        send(24'h000000, 0, 0, 0, '0, 0, got, gs);
        check("decay3", got, 24'h080000);

        // Saturation in both directions.
        do_reset();
        wr(0, 24'h800001);
        send(24'h7FFFFF, 0, 0, 0, '0, 0, got, gs);
        check("satp0", {gs, got}, {1'b0, 24'h7FFFFF});
        send(24'h7FFFFF, 0, 0, 0, '0, 0, got, gs);
        check("satp1", {gs, got}, {1'b1, 24'h7FFFFF});
        send(24'h800000, 0, 0, 0, '0, 0, got, gs);
        send(24'h800000, 0, 0, 0, '0, 0, got, gs);
        check("satn", {gs, got}, {1'b1, 24'h800000});

        // Coefficient write timing: during MAC ignored, in IDLE with accept applied,
        // address ORDER ignored.
        do_reset();
        wr(0, 24'hC00000);
        send(24'h400000, 0, 0, 0, '0, 0, got, gs);
        send(24'h000000, 0, 0, 0, '0, 1, got, gs);
        check("wr_mac", got, 24'h200000);
        send(24'h000000, 0, 1, 0, 24'h000000, 0, got, gs);
        check("wr_idle", got, 24'h000000);
        wr(ORDER, 24'h400000);
        send(24'h100000, 0, 0, 0, '0, 0, got, gs);
        check("wr_oob", got, 24'h100000);

        // Reset in the second MAC cycle.
        wr(0, 24'hC00000);
        bus.iv_din  = 24'h400000;
        bus.i_valid = 1'b1;
        tick();
        bus.i_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
        check("mrst_valid", bus.o_valid, 1'b0);
        check("mrst_ready", bus.o_ready, 1'b1);
        check("mrst_dout",  bus.ov_dout, '0);
        send(24'h400000, 0, 0, 0, '0, 0, got, gs);
        check("mrst_out", got, 24'h400000);
        send(24'h100000, 0, 0, 0, '0, 0, got, gs);
        check("mrst_hist", got, 24'h100000);

        // Randomized samples, coefficients, backpressure and ignored writes.
        do_reset();
        for (int n = 0; n < 40; n++) begin
            logic [DW-1:0] cv;
            if ($urandom_range(0, 3) == 0) begin
                cv = ($urandom_range(0, 7) == 0) ? DW'($urandom)
                                                 : DW'($urandom_range(0, 24'h3FFFFF) - 32'h200000);
                wr(int'($urandom_range(0, 3)), cv);
            end
            cv = DW'($urandom_range(0, 24'h3FFFFF) - 32'h200000);
            send(DW'($urandom), int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)),
                 int'($urandom_range(0, 3)), cv, bit'($urandom_range(0, 1)), got, gs);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/iir_allpole_serial.md
Name: iir_allpole_serial

Overview:
- Time-multiplexed all-pole (recursive) filter section: y[n] = x[n] - sum(k=1..ORDER) a[k]*y[n-k]; the inverse, feedback counterpart of the transposed-form FIR tap chain.
- Uses one multiplier, a loadable coefficient register bank and a ready/valid stream on both sides.
- Sits downstream of the FIR chain in the audio/DSP path; also serves as an equaliser/inverse-filter stage.

Parameters:
- DATA_WIDTH, 24, sample and coefficient width, signed Q1.(DATA_WIDTH-1)
- ORDER, 4, number of feedback coefficients/history taps, range 1..16

Ports:
- i_clk  in  1  clock
- i_rst  in  1  synchronous active-high reset
- iv_din  in  DATA_WIDTH  input sample x[n], signed Q1.23
- i_valid  in  1  iv_din valid
- o_ready  out  1  block can accept a sample
- ov_dout  out  DATA_WIDTH  output sample y[n], signed Q1.23
- o_valid  out  1  ov_dout valid
- i_ready  in  1  downstream accepts ov_dout
- i_coef_we  in  1  coefficient write strobe
- iv_coef_addr  in  clog2(ORDER)  coefficient index; 0 selects a[1]
- iv_coef  in  DATA_WIDTH  coefficient value, signed Q1.23
- o_sat  out  1  current ov_dout was saturated; valid while o_valid=1

Behaviour:
- Reset: ov_dout=0, o_valid=0, o_sat=0, o_ready=1; history y[n-1..n-ORDER]=0; all coefficients=0 (pass-through); FSM to IDLE; any in-flight sample discarded.
- Reset has priority over every other input in the same cycle.
- ACC_W = 2*DATA_WIDTH + clog2(ORDER+1) + 1. Accumulator is signed, in Q.(2*DATA_WIDTH-2) format.
- IDLE: o_ready=1.
  - On i_valid&&o_ready: acc <= sign-extended iv_din <<< (DATA_WIDTH-1); k <= 0; go to MAC.
  - i_coef_we is honoured only in IDLE: coef[iv_coef_addr] <= iv_coef.
  - A write to an address >= ORDER is ignored.
  - If a write and a sample accept occur in the same cycle, the write lands first and is used for that sample.
- MAC: o_ready=0. Each cycle: acc <= acc - coef[k]*hist[k], where hist[0]=y[n-1]; k++.
  - After exactly ORDER cycles (k==ORDER-1 processed), go to OUT.
  - i_coef_we is ignored in this state.
- OUT entry: ov_dout <= acc[2*DATA_WIDTH-2 : DATA_WIDTH-1], i.e. floor truncation, no rounding.
  - If acc[ACC_W-1 : 2*DATA_WIDTH-2] is not all-equal, saturate instead: 0x7FFFFF if acc>0, else 0x800000; set o_sat=1, else o_sat=0.
  - o_valid=1.
- OUT: ov_dout, o_sat and o_valid are held stable until i_ready.
  - On o_valid&&i_ready: the history shifts (hist[0] <= ov_dout, the saturated value; hist[k] <= hist[k-1]); o_valid <= 0; go to IDLE.
  - o_ready stays 0 throughout OUT; coefficient writes are ignored.
- Latency: sample accepted in cycle t -> o_valid high in cycle t+ORDER+1.
- Peak throughput: one sample per ORDER+2 cycles, with i_ready held high and i_valid presented in the IDLE cycle.
- Overflow inside the accumulator cannot occur by construction of ACC_W; only the output is saturated.
- iv_din is sampled only on the accept cycle and may change afterwards.

Test Plan:
- Pass-through: after reset (coefs 0), send 0x123456, 0x800000, 0x7FFFFF -> outputs identical, o_sat=0, each o_valid exactly ORDER+1 cycles after its accept.
- First-order decay: write addr0=0xC00000 (a1=-0.5), others 0; send 0x400000 then three 0x000000 -> ov_dout = 0x400000, 0x200000, 0x100000, 0x080000.
- Saturation: a1=0x800001, send 0x7FFFFF twice -> first output 0x7FFFFF with o_sat=0; second output 0x7FFFFF with o_sat=1; history holds 0x7FFFFF. Repeat with input 0x800000 -> output 0x800000, o_sat=1.
- Backpressure: hold i_ready=0 for 5 cycles in OUT -> ov_dout/o_sat stable, o_valid=1, o_ready=0, i_valid ignored. Release -> the next sample still uses the correct history.
- Coefficient write timing: in the decay setup, pulse i_coef_we with addr0=0x000000 during MAC -> ignored, output matches the decay value. Same write in IDLE alongside an accept -> takes effect for that sample. Write to addr=ORDER -> no effect.
- Reset mid-operation: assert i_rst in the 2nd MAC cycle -> next cycle o_valid=0, o_ready=1, ov_dout=0. A subsequent input 0x400000 outputs 0x400000 (coefs and history cleared).
